// File: rtl/serial_sub5.sv
// Bit-serial subtractor: x - y, LSB first, one full-adder cell (a + ~b + carry).
// Fixed latency of WIDTH+1 edges from start acceptance to the done pulse.
module serial_sub5 #(
   parameter int unsigned WIDTH = 5
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] x,
   input  logic [WIDTH-1:0] y,
   output logic [WIDTH-1:0] diff,
   output logic             borrowOut,
   output logic             overflow,
   output logic             busy,
   output logic             done
);

   localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t             state_q, state_d;
   logic [WIDTH-1:0]   xs_q, xs_d;
   logic [WIDTH-1:0]   ys_q, ys_d;
   logic [WIDTH-1:0]   res_q, res_d;
   logic [WIDTH-1:0]   diff_q, diff_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               carry_q, carry_d;
   logic               borrow_q, borrow_d;
   logic               ovf_q, ovf_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;

   logic               nb_c;
   logic               sum_c;
   logic               cout_c;
   logic [WIDTH-1:0]   res_shift_c;

   // Next-state, datapath and registered-output computation
   always_comb begin
      state_d  = state_q;
      xs_d     = xs_q;
      ys_d     = ys_q;
      res_d    = res_q;
      diff_d   = diff_q;
      cnt_d    = cnt_q;
      carry_d  = carry_q;
      borrow_d = borrow_q;
      ovf_d    = ovf_q;

      nb_c   = ~ys_q[0];
      sum_c  = xs_q[0] ^ nb_c ^ carry_q;
      cout_c = (xs_q[0] & nb_c) | (xs_q[0] & carry_q) | (nb_c & carry_q);

      // Result register fills from the MSB side
      res_shift_c            = res_q >> 1;
      res_shift_c[WIDTH-1]   = sum_c;

      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = RUN;
               xs_d    = x;
               ys_d    = y;
               carry_d = 1'b1;
               cnt_d   = '0;
            end
         end
         RUN: begin
            carry_d = cout_c;
            res_d   = res_shift_c;
            xs_d    = xs_q >> 1;
            ys_d    = ys_q >> 1;
            cnt_d   = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(WIDTH - 1)) begin
               state_d  = DONE;
               diff_d   = res_shift_c;
               borrow_d = ~cout_c;
               // xs_q[0]/ys_q[0] now hold the operand sign bits
               ovf_d    = (xs_q[0] ^ ys_q[0]) & (sum_c ^ xs_q[0]);
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      busy_d = (state_d != IDLE);
      done_d = (state_d == DONE);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q  <= IDLE;
         xs_q     <= '0;
         ys_q     <= '0;
         res_q    <= '0;
         diff_q   <= '0;
         cnt_q    <= '0;
         carry_q  <= 1'b0;
         borrow_q <= 1'b0;
         ovf_q    <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         xs_q     <= xs_d;
         ys_q     <= ys_d;
         res_q    <= res_d;
         diff_q   <= diff_d;
         cnt_q    <= cnt_d;
         carry_q  <= carry_d;
         borrow_q <= borrow_d;
         ovf_q    <= ovf_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
      end
   end

   assign diff      = diff_q;
   assign borrowOut = borrow_q;
   assign overflow  = ovf_q;
   assign busy      = busy_q;
   assign done      = done_q;

endmodule

// File: tb/tb_serial_sub5.sv
// Directed bench for serial_sub5 (WIDTH=5) with hand-computed expected results.
module tb_serial_sub5;

   localparam int unsigned WIDTH = 5;

   logic             clock;
   logic             reset;
   logic             start;
   logic [WIDTH-1:0] x;
   logic [WIDTH-1:0] y;
   logic [WIDTH-1:0] diff;
   logic             borrowOut;
   logic             overflow;
   logic             busy;
   logic             done;

   int errors = 0;
   int checks = 0;
   logic [WIDTH-1:0] prev_diff;
   int done_cnt;
   int first_done;
   int second_done;

   serial_sub5 #(.WIDTH(WIDTH)) dut (
      .clock     (clock),
      .reset     (reset),
      .start     (start),
      .x         (x),
      .y         (y),
      .diff      (diff),
      .borrowOut (borrowOut),
      .overflow  (overflow),
      .busy      (busy),
      .done      (done)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Advance one rising edge, then settle before sampling/driving
   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One start pulse, then check every cycle through the done pulse
   task automatic run_op(input string tag, input logic [WIDTH-1:0] xv, input logic [WIDTH-1:0] yv,
                         input logic [WIDTH-1:0] ed, input logic eb, input logic eo);
      x = xv; y = yv; start = 1'b1;
      tick();                                   // edge 1
      start = 1'b0;
      x = ~xv; y = ~yv;                         // must not affect the result
      chk({tag, ".busy1"}, 32'(busy), 32'd1);
      for (int e = 2; e <= 5; e++) begin
         tick();
         chk({tag, ".run_done"}, 32'(done), 32'd0);
         chk({tag, ".run_diff_hold"}, 32'(diff), 32'(prev_diff));
      end
      tick();                                   // edge 6
      chk({tag, ".done"}, 32'(done), 32'd1);
      chk({tag, ".busy"}, 32'(busy), 32'd1);
      chk({tag, ".diff"}, 32'(diff), 32'(ed));
      chk({tag, ".borrow"}, 32'(borrowOut), 32'(eb));
      chk({tag, ".ovf"}, 32'(overflow), 32'(eo));
      tick();                                   // edge 7
      chk({tag, ".done_end"}, 32'(done), 32'd0);
      chk({tag, ".busy_end"}, 32'(busy), 32'd0);
      chk({tag, ".diff_keep"}, 32'(diff), 32'(ed));
      prev_diff = ed;
   endtask

   initial begin
      reset = 1'b1; start = 1'b1; x = 5'b10101; y = 5'b01010;
      tick();
      tick();
      chk("rst.busy", 32'(busy), 32'd0);
      chk("rst.done", 32'(done), 32'd0);
      chk("rst.diff", 32'(diff), 32'd0);
      chk("rst.borrow", 32'(borrowOut), 32'd0);
      chk("rst.ovf", 32'(overflow), 32'd0);
      reset = 1'b0; start = 1'b0;
      prev_diff = '0;
      tick();

      run_op("t5m3",    5'b00101, 5'b00011, 5'b00010, 1'b0, 1'b0);
      run_op("t3m5",    5'b00011, 5'b00101, 5'b11110, 1'b1, 1'b0);
      run_op("tneg16",  5'b10000, 5'b00001, 5'b01111, 1'b0, 1'b1);
      run_op("t15mneg", 5'b01111, 5'b11111, 5'b10000, 1'b1, 1'b1);

      // start held high: back-to-back operations on x = y
      x = 5'b11111; y = 5'b11111; start = 1'b1;
      done_cnt = 0; first_done = 0; second_done = 0;
      for (int e = 1; e <= 16; e++) begin
         tick();
         if (done) begin
            done_cnt++;
            if (done_cnt == 1) begin
               first_done = e;
               chk("b2b.diff", 32'(diff), 32'd0);
               chk("b2b.borrow", 32'(borrowOut), 32'd0);
               chk("b2b.ovf", 32'(overflow), 32'd0);
            end else if (done_cnt == 2) begin
               second_done = e;
            end
         end
      end
      start = 1'b0;
      chk("b2b.first_edge", 32'(first_done), 32'd6);
      chk("b2b.gap", 32'(second_done - first_done), 32'd7);
      for (int e = 0; e < 8; e++) tick();
      chk("b2b.idle_busy", 32'(busy), 32'd0);
      prev_diff = '0;

      // Second start during RUN is ignored
      x = 5'b00101; y = 5'b00011; start = 1'b1;
      tick();                                   // edge 1
      start = 1'b0;
      tick();                                   // edge 2
      x = 5'b11111; y = 5'b00001; start = 1'b1;
      tick();                                   // edge 3
      start = 1'b0;
      tick(); tick(); tick();                   // edges 4..6
      chk("ign.done", 32'(done), 32'd1);
      chk("ign.diff", 32'(diff), 32'b00010);
      done_cnt = 0;
      for (int e = 7; e <= 14; e++) begin
         tick();
         if (done) done_cnt++;
      end
      chk("ign.extra_done", 32'(done_cnt), 32'd0);
      prev_diff = 5'b00010;

      // Reset aborts an operation in progress
      x = 5'b00110; y = 5'b00001; start = 1'b1;
      tick();                                   // edge 1
      start = 1'b0;
      tick(); tick();                           // edges 2,3
      reset = 1'b1;
      tick();                                   // edge 4
      reset = 1'b0;
      chk("abort.busy", 32'(busy), 32'd0);
      chk("abort.done", 32'(done), 32'd0);
      chk("abort.diff", 32'(diff), 32'd0);
      done_cnt = 0;
      for (int e = 0; e < 8; e++) begin
         tick();
         if (done) done_cnt++;
      end
      chk("abort.no_done", 32'(done_cnt), 32'd0);
      prev_diff = '0;
      run_op("post_rst", 5'b01010, 5'b00100, 5'b00110, 1'b0, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
